beam_trig_recorder: RTL and testbench
=====================================

# beam_trig_recorder

Trigger recorder sitting directly downstream of the beam metadata builder: consumes its forwarded trigger strobe and 8-bit beam metadata, applies a programmable holdoff, timestamps each accepted trigger and buffers `{timestamp, metadata}` records in a small FIFO. Records drain through a valid/ready stream toward the readout/TURF link. Running accept and drop counters are exported for housekeeping.

## Interface
Parameters:
- `TS_WIDTH`, 24: timestamp width in bits; record width is `TS_WIDTH+8`.
- `FIFO_DEPTH`, 16: record FIFO depth; power of two, 4..64.

Ports:
- `clk_i`  in  1: trigger-domain clock, same clock as the metadata builder.
- `rstn_i`  in  1: reset; asynchronous assert, active-low.
- `trig_i`  in  1: trigger strobe, one cycle per trigger.
- `meta_i`  in  8: beam metadata, valid in the same cycle as `trig_i`.
- `en_i`  in  1: recorder enable.
- `holdoff_i`  in  8: dead time in cycles after an accepted trigger; sampled at acceptance.
- `rec_data_o`  out  TS_WIDTH+8: record, `{timestamp, meta}`, meta in bits [7:0].
- `rec_valid_o`  out  1: record available.
- `rec_ready_i`  in  1: downstream accepts the record when `rec_valid_o & rec_ready_i`.
- `busy_o`  out  1: high while in HOLDOFF.
- `trig_count_o`  out  16: triggers accepted into the FIFO; wraps.
- `drop_count_o`  out  16: triggers lost to a full FIFO; saturates at 0xFFFF.

## Operation
- Timestamp counter `ts` runs freely from reset, incrementing every cycle and wrapping at 2^TS_WIDTH. It is not gated by `en_i`.
- FSM states:
  - DISABLED: ignore `trig_i`; go to ARMED when `en_i`=1.
  - ARMED: when `trig_i`=1, the trigger is *qualified*. Load the holdoff counter with `holdoff_i` and go to HOLDOFF, or stay in ARMED if `holdoff_i`=0.
  - HOLDOFF: ignore `trig_i` and decrement the counter each cycle. Return to ARMED in the cycle after the counter reads 1.
  - From any state, `en_i`=0 goes to DISABLED next cycle and clears the holdoff counter.
- A qualified trigger in cycle N writes `{ts(N), meta_i(N)}` into the FIFO if the FIFO is not full in cycle N. On that write, `trig_count_o` increments.
- If the FIFO is full, the record is discarded and `drop_count_o` increments (saturating). Holdoff still starts.
- Full is judged on the registered occupancy only. A pop in the same cycle does not free a slot for that cycle's write.
- Triggers suppressed by HOLDOFF or DISABLED are not counted anywhere.
- FIFO is first-word-fall-through: `rec_data_o` is stable while `rec_valid_o`=1 and `rec_ready_i`=0.
- The FIFO drains regardless of `en_i`.

## Timing
- Reset (async assert, sync release): state DISABLED, `ts`=0, FIFO empty. All outputs are 0: `rec_valid_o`, `rec_data_o`, `busy_o`, both counters.
- Reset mid-operation flushes buffered records without emitting them.
- Input registration: `trig_i`/`meta_i` are registered once (cycle N+1). The FIFO write occurs at the N+1 edge.
- Latency: `rec_valid_o` rises at cycle N+2 for a trigger at N into an empty FIFO.
- Counter updates are visible at N+2.
- The timestamp is `ts` sampled in cycle N, not N+1.
- `busy_o` is high from N+1 for exactly `holdoff_i` cycles.
- The next trigger is qualified at the earliest in cycle N+1+`holdoff_i`.
- With `holdoff_i`=0, triggers on consecutive cycles are all qualified.
- Simultaneous write and pop with the FIFO neither full nor empty: occupancy is unchanged, both operations succeed.
- Write into an empty FIFO during a pop attempt: the pop is meaningless because `rec_valid_o`=0; the record appears next cycle.
- `en_i` falling in the same cycle as `trig_i` in ARMED: the trigger is still qualified, because state is evaluated before the transition.

## Structure
- Package `pueo_trig_rec_pkg`:
  - state enum `trig_rec_state_t` {DISABLED, ARMED, HOLDOFF};
  - `META_WIDTH`=8;
  - `COUNT_WIDTH`=16.
- Sub-module `trig_rec_fifo`: synchronous FWFT FIFO with parameters DEPTH and WIDTH.
  - Ports: `clk_i`, `rstn_i`, `wr_i`, `din_i`, `full_o`, `dout_o`, `valid_o`, `rd_i`.
  - Occupancy counter of log2(DEPTH)+1 bits.
- Top level holds the FSM, holdoff counter, timestamp, input register and the statistics counters.

## Test plan
- Single trigger: reset, `en_i`=1, `holdoff_i`=0, `rec_ready_i`=1, pulse `trig_i` with meta 0xA5 when `ts`=100.
  - Expect `rec_valid_o` high for one cycle 2 cycles later with `rec_data_o`={100, 0xA5}.
  - Expect `trig_count_o`=1.
- Holdoff: `holdoff_i`=4, `trig_i` held high 12 cycles.
  - Expect records at offsets 0, 5, 10 only.
  - Expect `busy_o` high 4 cycles after each record.
  - Expect `trig_count_o`=3.
- Overflow: `FIFO_DEPTH`=16, `rec_ready_i`=0, `holdoff_i`=0, 20 consecutive triggers.
  - Expect 16 stored records, `drop_count_o`=4.
  - Then assert ready: expect the 16 records drained in order with timestamps consecutive.
- Backpressure at full with simultaneous pop: FIFO full, `rec_ready_i`=1 and `trig_i` in the same cycle.
  - Expect the trigger dropped (`drop_count_o`+1) and occupancy 15 afterward.
- Disable/reset: `en_i`=0 with triggers present: no records, no counter change, and stored records still drain.
  - Assert `rstn_i` low mid-stream: outputs 0 immediately, FIFO empty after release.
- Counter limits: force 65540 drops: expect `drop_count_o`=0xFFFF.
  - Force 65537 accepts: expect `trig_count_o`=1.
  - Run `ts` past 2^24: expect the timestamp to wrap to 0.

Source files
------------

// File: rtl/pueo_trig_rec_pkg.sv
// Shared types and widths for the beam trigger recorder.
package pueo_trig_rec_pkg;

  localparam int META_WIDTH  = 8;
  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    HOLDOFF  = 2'd2
  } trig_rec_state_t;

endpackage

// File: rtl/trig_rec_fifo.sv
// First-word-fall-through record FIFO; output reads zero while empty.
module trig_rec_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  input  logic             rd_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_i && (count_q != CNT_FULL);
    do_rd    = rd_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign valid_o = (count_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  // Full counts the write being presented now but never the pop in flight,
  // so a producer deciding one cycle ahead cannot overrun the buffer.
  assign full_o  = (count_q == CNT_FULL) || (wr_i && (count_q == CNT_LAST));

endmodule

// File: rtl/beam_trig_recorder.sv
// Trigger recorder: holdoff FSM, free-running timestamp, record FIFO and stats.
module beam_trig_recorder
  import pueo_trig_rec_pkg::*;
#(
  parameter int TS_WIDTH   = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         trig_i,
  input  logic [META_WIDTH-1:0]        meta_i,
  input  logic                         en_i,
  input  logic [7:0]                   holdoff_i,
  output logic [TS_WIDTH+META_WIDTH-1:0] rec_data_o,
  output logic                         rec_valid_o,
  input  logic                         rec_ready_i,
  output logic                         busy_o,
  output logic [COUNT_WIDTH-1:0]       trig_count_o,
  output logic [COUNT_WIDTH-1:0]       drop_count_o
);

  localparam int REC_W = TS_WIDTH + META_WIDTH;

  trig_rec_state_t        state_q, state_d;
  logic [7:0]             hcnt_q, hcnt_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic                   wr_q, wr_d;
  logic                   drop_q, drop_d;
  logic [REC_W-1:0]       rec_q, rec_d;
  logic [COUNT_WIDTH-1:0] trig_count_q, trig_count_d;
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                   qual;
  logic                   fifo_full;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= DISABLED;
    else         state_q <= state_d;
  end

  // Disable wins from any state; a trigger seen while ARMED is still qualified.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = ARMED;
        ARMED:    if (trig_i && (holdoff_i != 8'd0)) state_d = HOLDOFF;
        HOLDOFF:  if (hcnt_q == 8'd1) state_d = ARMED;
        default:  state_d = DISABLED;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == HOLDOFF);
    qual   = (state_q == ARMED) && trig_i;
  end

  always_comb begin
    ts_d = ts_q + 1'b1;
    if (!en_i)                  hcnt_d = 8'd0;
    else if (qual)              hcnt_d = holdoff_i;
    else if (state_q == HOLDOFF) hcnt_d = hcnt_q - 8'd1;
    else                        hcnt_d = hcnt_q;
    wr_d   = qual && !fifo_full;
    drop_d = qual && fifo_full;
    rec_d  = {ts_q, meta_i};
    trig_count_d = trig_count_q + COUNT_WIDTH'(wr_q);
    drop_count_d = (drop_q && (drop_count_q != '1)) ? drop_count_q + 1'b1 : drop_count_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hcnt_q       <= 8'd0;
      ts_q         <= '0;
      wr_q         <= 1'b0;
      drop_q       <= 1'b0;
      trig_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      hcnt_q       <= hcnt_d;
      ts_q         <= ts_d;
      wr_q         <= wr_d;
      drop_q       <= drop_d;
      trig_count_q <= trig_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Record payload carries the timestamp of the trigger cycle, not the write cycle.
  always_ff @(posedge clk_i) begin
    rec_q <= rec_d;
  end

  trig_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_i    (wr_q),
    .din_i   (rec_q),
    .full_o  (fifo_full),
    .dout_o  (rec_data_o),
    .valid_o (rec_valid_o),
    .rd_i    (rec_ready_i)
  );

  assign trig_count_o = trig_count_q;
  assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_beam_trig_recorder.sv
// Directed bench for beam_trig_recorder with hand-computed expectations.
module tb_beam_trig_recorder;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        trig_i;
  logic [7:0]  meta_i;
  logic        en_i;
  logic [7:0]  holdoff_i;
  logic [31:0] rec_data_o;
  logic        rec_valid_o;
  logic        rec_ready_i;
  logic        busy_o;
  logic [15:0] trig_count_o;
  logic [15:0] drop_count_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned ts_m;

  beam_trig_recorder #(.TS_WIDTH(24), .FIFO_DEPTH(16)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .trig_i       (trig_i),
    .meta_i       (meta_i),
    .en_i         (en_i),
    .holdoff_i    (holdoff_i),
    .rec_data_o   (rec_data_o),
    .rec_valid_o  (rec_valid_o),
    .rec_ready_i  (rec_ready_i),
    .busy_o       (busy_o),
    .trig_count_o (trig_count_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: the value the timestamp should hold each cycle.
  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) ts_m <= 0;
    else         ts_m <= ts_m + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkrec(input int unsigned t, input int unsigned m);
    logic [31:0] r;
    r = {t[23:0], m[7:0]};
    return 64'(r);
  endfunction

  initial begin
    int unsigned base, p, r, s;
    logic        exp_v;

    rstn_i = 1'b0; trig_i = 1'b0; meta_i = 8'h00; en_i = 1'b0;
    holdoff_i = 8'd0; rec_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(rec_valid_o), 64'd0);
    chk("rst_data",  64'(rec_data_o),  64'd0);
    chk("rst_busy",  64'(busy_o),      64'd0);
    chk("rst_trig",  64'(trig_count_o), 64'd0);
    chk("rst_drop",  64'(drop_count_o), 64'd0);

    // Single trigger at ts=100
    rstn_i = 1'b1; en_i = 1'b1; rec_ready_i = 1'b1;
    for (int g = 0; g < 300 && ts_m != 100; g++) step();
    chk("single_ts_reached", 64'(ts_m), 64'd100);
    trig_i = 1'b1; meta_i = 8'hA5;
    step();
    trig_i = 1'b0;
    chk("single_n1_valid", 64'(rec_valid_o), 64'd0);
    step();
    chk("single_valid", 64'(rec_valid_o), 64'd1);
    chk("single_data",  64'(rec_data_o), mkrec(100, 8'hA5));
    chk("single_trig",  64'(trig_count_o), 64'd1);
    step();
    chk("single_n3_valid", 64'(rec_valid_o), 64'd0);

    // Holdoff of 4 with trigger held for 12 cycles
    holdoff_i = 8'd4;
    base = ts_m;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i == 2) || (i == 7) || (i == 12);
      chk($sformatf("hold_valid_%0d", i), 64'(rec_valid_o), 64'(exp_v));
      if (exp_v) chk($sformatf("hold_data_%0d", i), 64'(rec_data_o),
                     mkrec(base + i - 2, 32'h10 + i - 2));
      chk($sformatf("hold_busy_%0d", i), 64'(busy_o),
          64'(((i >= 1) && (i <= 4)) || ((i >= 6) && (i <= 9)) || ((i >= 11) && (i <= 14))));
      trig_i = (i < 12);
      meta_i = 8'(32'h10 + i);
      step();
    end
    chk("hold_trig", 64'(trig_count_o), 64'd4);
    holdoff_i = 8'd0;

    // Overflow: 20 back-to-back triggers, no readout
    rec_ready_i = 1'b0;
    p = ts_m;
    for (int i = 0; i < 20; i++) begin
      trig_i = 1'b1; meta_i = 8'(i);
      step();
    end
    trig_i = 1'b0;
    step(); step();
    chk("ovf_drop",       64'(drop_count_o), 64'd4);
    chk("ovf_trig",       64'(trig_count_o), 64'd20);
    chk("ovf_head_valid", 64'(rec_valid_o),  64'd1);
    chk("ovf_head_data",  64'(rec_data_o),   mkrec(p, 0));

    // Trigger and pop in the same cycle while full: trigger is dropped
    trig_i = 1'b1; meta_i = 8'hEE; rec_ready_i = 1'b1;
    step();
    trig_i = 1'b0; rec_ready_i = 1'b0;
    step();
    chk("bp_drop", 64'(drop_count_o), 64'd5);
    chk("bp_trig", 64'(trig_count_o), 64'd20);
    chk("bp_head", 64'(rec_data_o), mkrec(p + 1, 1));
    rec_ready_i = 1'b1;
    for (int k = 2; k < 16; k++) begin
      step();
      chk($sformatf("drain_%0d", k), 64'(rec_data_o), mkrec(p + k, k));
    end
    step();
    chk("drain_empty", 64'(rec_valid_o), 64'd0);

    // Disable: trigger coincident with en falling is kept, later ones ignored
    rec_ready_i = 1'b0;
    trig_i = 1'b1; meta_i = 8'h31; r = ts_m;
    step();
    trig_i = 1'b0;
    step();
    en_i = 1'b0; trig_i = 1'b1; meta_i = 8'h32; s = ts_m;
    step();
    meta_i = 8'h40;
    repeat (5) step();
    trig_i = 1'b0;
    step(); step();
    chk("dis_trig", 64'(trig_count_o), 64'd22);
    chk("dis_drop", 64'(drop_count_o), 64'd5);
    chk("dis_busy", 64'(busy_o), 64'd0);
    chk("dis_head", 64'(rec_data_o), mkrec(r, 8'h31));
    rec_ready_i = 1'b1;
    step();
    chk("dis_second", 64'(rec_data_o), mkrec(s, 8'h32));
    step();
    chk("dis_empty", 64'(rec_valid_o), 64'd0);

    // Reset in the middle of buffered data
    en_i = 1'b1; rec_ready_i = 1'b0;
    step();
    trig_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      meta_i = 8'(32'h50 + i);
      step();
    end
    trig_i = 1'b0;
    step(); step();
    chk("rm_pre_valid", 64'(rec_valid_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    chk("rm_valid", 64'(rec_valid_o),  64'd0);
    chk("rm_data",  64'(rec_data_o),   64'd0);
    chk("rm_trig",  64'(trig_count_o), 64'd0);
    chk("rm_drop",  64'(drop_count_o), 64'd0);
    step();
    rstn_i = 1'b1;
    step();
    chk("rm_after_valid", 64'(rec_valid_o), 64'd0);

    // Drop counter saturation: 16 stored then 65540 drops
    trig_i = 1'b1;
    repeat (16 + 65534) step();
    trig_i = 1'b0;
    step(); step();
    chk("sat_trig", 64'(trig_count_o), 64'd16);
    chk("sat_fffe", 64'(drop_count_o), 64'hFFFE);
    trig_i = 1'b1;
    repeat (6) step();
    trig_i = 1'b0;
    step(); step();
    chk("sat_ffff", 64'(drop_count_o), 64'hFFFF);

    // Accept counter wrap after 65535 preloaded accepts
    rec_ready_i = 1'b1;
    repeat (20) step();
    chk("wrap_drained", 64'(rec_valid_o), 64'd0);
    force dut.trig_count_q = 16'hFFFF;
    step();
    force dut.trig_count_q = 16'hFFFF;
    release dut.trig_count_q;
    trig_i = 1'b1; meta_i = 8'h61;
    step();
    trig_i = 1'b0;
    step();
    chk("wrap_trig_0", 64'(trig_count_o), 64'd0);
    trig_i = 1'b1; meta_i = 8'h62;
    step();
    trig_i = 1'b0;
    step();
    chk("wrap_trig_1", 64'(trig_count_o), 64'd1);
    step();

    // Timestamp wrap at 2^24
    rec_ready_i = 1'b0;
    force dut.ts_q = 24'hFFFFFE;
    step();
    force dut.ts_q = 24'hFFFFFF;
    release dut.ts_q;
    trig_i = 1'b1; meta_i = 8'h71;
    step();
    meta_i = 8'h72;
    step();
    trig_i = 1'b0;
    step();
    chk("tswrap_last", 64'(rec_data_o), mkrec(32'hFFFFFF, 8'h71));
    rec_ready_i = 1'b1;
    step();
    chk("tswrap_zero", 64'(rec_data_o), mkrec(0, 8'h72));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
